// File: rtl/clk_period_monitor_if.sv
// clk_period_monitor_if: groups the control inputs and measurement outputs of
// clk_period_monitor. The master side (system/bench) drives enable, the
// monitored clock and the expected period/tolerance. The slave side (the
// monitor) returns the measurement results.
interface clk_period_monitor_if #(
    parameter int W = 16
);
    logic         en;
    logic         mon_in;
    logic [W-1:0] exp_period;
    logic [W-1:0] tol;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic         meas_valid;
    logic         period_err;
    logic         duty_err;
    logic         locked;
    logic         timeout;

    modport master (
        output en, mon_in, exp_period, tol,
        input  period, high_cnt, meas_valid, period_err, duty_err, locked, timeout
    );

    modport slave (
        input  en, mon_in, exp_period, tol,
        output period, high_cnt, meas_valid, period_err, duty_err, locked, timeout
    );
endinterface

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures the period and high time of a divided clock
// (mon_in) in cycles of its fast source clock (clk), flags period and duty
// deviations against exp_period +/- tol, and tracks frequency lock.
// Optional feature: define DUTY_CHECK_EN to build the high-time counter and
// the duty check; without it high_cnt and duty_err are tied to 0.
//
// Output handshake: meas_valid is a one-cycle strobe with no ready/backpressure.
// period, high_cnt, period_err and duty_err change only on the edge that raises
// meas_valid and then hold until the next strobe, so a consumer may sample them
// either on the strobe or at any later time. timeout is an independent strobe.
module clk_period_monitor #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    clk_period_monitor_if.slave bus,
    output logic [1:0]          dbg_state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;

    localparam int             LCW      = $clog2(LOCK_COUNT + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_COUNT);
    localparam logic [W-1:0]   CNT_MAX  = '1;
    localparam logic [W-1:0]   CNT_ONE  = W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   lvl;
    logic                   rise;
    logic                   take_meas;
    logic [1:0]             state_q, state_d;
    logic [W-1:0]           cnt_q, cnt_d;
    logic [W-1:0]           period_q, period_d;
    logic                   perr_q, perr_d;
    logic                   mv_q, mv_d;
    logic                   to_q, to_d;
    logic                   locked_q, locked_d;
    logic [LCW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [W:0]             pdiff, pabs;
    logic                   period_bad;
    logic                   duty_bad;

    // Synchronizer chain plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.mon_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl       = sync_q[SYNC_STAGES-1];
    assign rise      = lvl & ~dly_q;
    assign take_meas = bus.en && (state_q == S_MEAS) && rise;

    // Period deviation: unsigned difference at W+1 bits, then magnitude.
    assign pdiff      = {1'b0, cnt_q} - {1'b0, bus.exp_period};
    assign pabs       = pdiff[W] ? ((W+1)'(0) - pdiff) : pdiff;
    assign period_bad = pabs > {1'b0, bus.tol};

    // Next-state logic: FSM, period counter, measurement capture and lock tracking.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        perr_d     = perr_q;
        mv_d       = 1'b0;
        to_d       = 1'b0;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        if (!bus.en) begin
            // Disable wins over everything, including a coincident rise.
            state_d    = S_IDLE;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    // First edge after arming only starts the count.
                    if (rise) begin
                        state_d = S_MEAS;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        period_d = cnt_q;
                        perr_d   = period_bad;
                        mv_d     = 1'b1;
                        cnt_d    = CNT_ONE;
                        if (period_bad || duty_bad) begin
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                        end else if (lock_cnt_q != LOCK_MAX) begin
                            lock_cnt_d = lock_cnt_q + LCW'(1);
                            locked_d   = (lock_cnt_q + LCW'(1)) == LOCK_MAX;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // Counter exhausted without an edge: drop lock and re-arm.
                        to_d       = 1'b1;
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                        state_d    = S_ARM;
                    end else begin
                        // Below CNT_MAX here, so the increment never wraps.
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            perr_q     <= 1'b0;
            mv_q       <= 1'b0;
            to_q       <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            perr_q     <= perr_d;
            mv_q       <= mv_d;
            to_q       <= to_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

`ifdef DUTY_CHECK_EN
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] high_q;
    logic         derr_q;
    logic [W+1:0] ddiff, dabs;

    // Duty deviation |2*hi - cnt|; W+2 bits keep the signed range intact.
    assign ddiff    = {1'b0, hi_q, 1'b0} - {2'b00, cnt_q};
    assign dabs     = ddiff[W+1] ? ((W+2)'(0) - ddiff) : ddiff;
    assign duty_bad = dabs > {2'b00, bus.tol};

    // High-time accumulator: restarts on each counted edge, then counts synced-high cycles.
    always_comb begin
        hi_d = hi_q;
        if (bus.en && rise && (state_q != S_IDLE)) begin
            hi_d = CNT_ONE;
        end else if (bus.en && (state_q == S_MEAS) && (cnt_q != CNT_MAX) && lvl) begin
            hi_d = hi_q + CNT_ONE;
        end
    end

    // High-time counter and captured duty results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            high_q <= '0;
            derr_q <= 1'b0;
        end else begin
            hi_q <= hi_d;
            if (take_meas) begin
                high_q <= hi_q;
                derr_q <= duty_bad;
            end
        end
    end

    assign bus.high_cnt = high_q;
    assign bus.duty_err = derr_q;
`else
    assign duty_bad     = 1'b0;
    assign bus.high_cnt = '0;
    assign bus.duty_err = 1'b0;
`endif

    assign bus.period     = period_q;
    assign bus.period_err = perr_q;
    assign bus.meas_valid = mv_q;
    assign bus.timeout    = to_q;
    assign bus.locked     = locked_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: drives clk-derived waveforms on mon_in and compares
// every output on every cycle against an edge-indexed reference model, plus
// hand-computed checkpoints for the directed scenarios.
module tb_clk_period_monitor;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LC   = 4;
    localparam int MAXC = (1 << W) - 1;
`ifdef DUTY_CHECK_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    clk_period_monitor_if #(.W(W)) bus ();

    clk_period_monitor #(
        .W          (W),
        .SYNC_STAGES(SYNC),
        .LOCK_COUNT (LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int mv_seen = 0;
    int to_seen = 0;
    bit cmp_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // ---------------- reference model ----------------
    // mon_in is sampled at every clk edge; the monitor reacts to the sample
    // taken SYNC edges earlier, so a rise is seen at edge e when samples
    // e-2 / e-3 are 1 / 0. A measured period is the edge-index difference of
    // two seen rises; the high time is the count of high samples in between.
    bit m_hist[int];
    int edge_n = 0;
    bit active, started;
    int start_e, lockn;
    int m_period, m_high;
    bit m_mv, m_perr, m_derr, m_locked, m_to;

    function automatic bit mh(input int k);
        return m_hist.exists(k) ? m_hist[k] : 1'b0;
    endfunction

    task automatic model_clear();
        active = 0; started = 0; start_e = 0; lockn = 0;
        m_period = 0; m_high = 0;
        m_mv = 0; m_perr = 0; m_derr = 0; m_locked = 0; m_to = 0;
    endtask

    always @(posedge rst) model_clear();

    always @(posedge clk) begin
        int e, p, h, expv, tolv;
        bit rise_seen, perr, derr;
        edge_n++;
        e = edge_n;
        if (rst) begin
            m_hist[e] = 1'b0;
            model_clear();
        end else begin
            m_hist[e] = bus.mon_in;
            rise_seen = mh(e - 2) && !mh(e - 3);
            m_mv = 0;
            m_to = 0;
            if (!bus.en) begin
                active = 0; started = 0; lockn = 0; m_locked = 0;
            end else if (!active) begin
                active = 1;
            end else if (!started) begin
                if (rise_seen) begin
                    started = 1;
                    start_e = e;
                end
            end else begin
                p = e - start_e;
                if (rise_seen) begin
                    h = 0;
                    for (int j = start_e; j < e; j++) h += mh(j - 2);
                    expv = int'(bus.exp_period);
                    tolv = int'(bus.tol);
                    perr = iabs(p - expv) > tolv;
                    derr = DUTY && (iabs(2 * h - p) > tolv);
                    m_period = p;
                    m_high   = DUTY ? h : 0;
                    m_perr   = perr;
                    m_derr   = derr;
                    m_mv     = 1;
                    if (perr || derr) begin
                        lockn = 0;
                        m_locked = 0;
                    end else begin
                        if (lockn < LC) lockn++;
                        m_locked = (lockn == LC);
                    end
                    start_e = e;
                end else if (p == MAXC) begin
                    m_to = 1; lockn = 0; m_locked = 0; started = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (bus.meas_valid) mv_seen++;
        if (bus.timeout) to_seen++;
        if (cmp_on) begin
            check("period",     bus.period,     m_period);
            check("high_cnt",   bus.high_cnt,   m_high);
            check("meas_valid", bus.meas_valid, m_mv);
            check("period_err", bus.period_err, m_perr);
            check("duty_err",   bus.duty_err,   m_derr);
            check("locked",     bus.locked,     m_locked);
            check("timeout",    bus.timeout,    m_to);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // n full periods of length p with high time h, starting with the rising edge.
    task automatic run(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                bus.mon_in = (i < h);
                tick();
            end
        end
    endtask

    task automatic set_cfg(input int e, input int t);
        bus.exp_period = W'(e);
        bus.tol        = W'(t);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".period"},     bus.period,     0);
        check({tag, ".high_cnt"},   bus.high_cnt,   0);
        check({tag, ".meas_valid"}, bus.meas_valid, 0);
        check({tag, ".period_err"}, bus.period_err, 0);
        check({tag, ".duty_err"},   bus.duty_err,   0);
        check({tag, ".locked"},     bus.locked,     0);
        check({tag, ".timeout"},    bus.timeout,    0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int mc, tc, p, h, n;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.mon_in = 1'b0;
        set_cfg(4, 0);
        ticks(4);
        check_all_zero("reset");
        check("reset.state", dbg_state, 0);
        rst = 1'b0;
        cmp_on = 1'b1;
        tick();

        // Divide-by-4, exp 4, tol 0: four measurements of 4, locked after the 4th.
        bus.en = 1'b1;
        ticks(3);
        mc = mv_seen;
        run(4, 2, 5);
        check("div4.meas_count", mv_seen - mc, 4);
        check("div4.period", bus.period, 4);
        check("div4.high_cnt", bus.high_cnt, DUTY ? 2 : 0);
        check("div4.period_err", bus.period_err, 0);
        check("div4.locked", bus.locked, 1);

        // Divide-by-6 against exp 4, then back to divide-by-4.
        run(6, 3, 4);
        check("div6.period", bus.period, 6);
        check("div6.period_err", bus.period_err, 1);
        check("div6.locked", bus.locked, 0);
        run(4, 2, 3);
        check("back4.locked_2good", bus.locked, 0);
        check("back4.period", bus.period, 4);
        run(4, 2, 1);
        check("back4.locked_3good", bus.locked, 0);
        run(4, 2, 1);
        check("back4.locked_4good", bus.locked, 1);

        // exp 5, tol 1: period 6 is in tolerance, period 7 is not.
        set_cfg(5, 1);
        run(6, 3, 5);
        check("tol.p6_period", bus.period, 6);
        check("tol.p6_err", bus.period_err, 0);
        check("tol.p6_locked", bus.locked, 1);
        run(7, 3, 2);
        check("tol.p7_period", bus.period, 7);
        check("tol.p7_err", bus.period_err, 1);
        check("tol.p7_locked", bus.locked, 0);

        // Period 8, high 2, tol 1: duty violation only when the check is built.
        set_cfg(8, 1);
        run(8, 2, 6);
        check("duty.period", bus.period, 8);
        check("duty.period_err", bus.period_err, 0);
        check("duty.duty_err", bus.duty_err, DUTY ? 1 : 0);
        check("duty.high_cnt", bus.high_cnt, DUTY ? 2 : 0);
        check("duty.locked", bus.locked, DUTY ? 0 : 1);

        // Lock, then hold mon_in low: exactly one timeout, then fresh measurement.
        set_cfg(4, 0);
        run(4, 2, 6);
        check("tmo.locked_before", bus.locked, 1);
        tc = to_seen;
        bus.mon_in = 1'b0;
        ticks(300);
        check("tmo.pulses", to_seen - tc, 1);
        check("tmo.locked_after", bus.locked, 0);
        mc = mv_seen;
        run(4, 2, 2);
        check("tmo.rearm_meas", mv_seen - mc, 1);
        check("tmo.rearm_period", bus.period, 4);

        // en dropped on the very cycle the rise is seen.
        run(4, 2, 3);
        mc = mv_seen;
        bus.mon_in = 1'b1;
        ticks(2);
        bus.en = 1'b0;
        tick();
        bus.mon_in = 1'b0;
        ticks(2);
        check("en0.no_meas", mv_seen - mc, 0);
        check("en0.period_hold", bus.period, 4);
        check("en0.locked", bus.locked, 0);
        bus.en = 1'b1;
        ticks(2);

        // Reset in the middle of a measurement.
        run(4, 2, 3);
        bus.mon_in = 1'b1;
        ticks(2);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        bus.mon_in = 1'b0;
        ticks(3);
        rst = 1'b0;
        mc = mv_seen;
        run(4, 2, 1);
        bus.mon_in = 1'b0;
        ticks(3);
        check("rst.first_rise_no_meas", mv_seen - mc, 0);
        run(4, 2, 1);
        check("rst.second_rise_meas", mv_seen - mc, 1);
        check("rst.period", bus.period, 7);

        // Randomized waveforms, configuration changes, enable drops and long gaps.
        for (int it = 0; it < 60; it++) begin
            p = $urandom_range(2, 20);
            h = $urandom_range(1, p - 1);
            n = $urandom_range(1, 6);
            set_cfg(p + $urandom_range(0, 2) - 1, $urandom_range(0, 2));
            run(p, h, n);
            if ($urandom_range(0, 9) == 0) begin
                bus.en = 1'b0;
                ticks($urandom_range(1, 4));
                bus.en = 1'b1;
            end
            if ($urandom_range(0, 14) == 0) begin
                bus.mon_in = 1'b0;
                ticks($urandom_range(250, 270));
            end
        end
        ticks(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_period_monitor.md
# clk_period_monitor

Measures the period and high time of a divided clock, in cycles of the fast source clock. Flags frequency and duty-cycle deviations and reports a lock status. It sits directly downstream of the generalized clock divider: the divider output drives `mon_in`, and the divider's source clock drives `clk`. It is used for bring-up checks and runtime supervision of every divider instance.

## Interface
- `W`, default 16: width of the measurement counters and of the period/tolerance fields.
- `SYNC_STAGES`, default 2: depth of the input synchronizer on `mon_in` (minimum 2).
- `LOCK_COUNT`, default 4: number of consecutive in-tolerance measurements needed to assert `locked`.

Ports:
- `clk`  in  1  source clock; all logic is on its posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  monitor enable; level-sensitive.
- `mon_in`  in  1  monitored divided clock; treated as asynchronous.
- `exp_period`  in  W  expected period in `clk` cycles.
- `tol`  in  W  allowed absolute deviation in cycles; an error occurs when the deviation is greater than `tol`.
- `period`  out  W  last measured period.
- `high_cnt`  out  W  last measured high time.
- `meas_valid`  out  1  one-cycle pulse when `period`/`high_cnt` update.
- `period_err`  out  1  result of the last period check; valid with `meas_valid` and held until the next one.
- `duty_err`  out  1  result of the last duty check (see Configuration).
- `locked`  out  1  frequency lock status.
- `timeout`  out  1  one-cycle pulse when no rising edge arrives within range.

## Operation
- **Synchronizer:** `SYNC_STAGES` flops on `mon_in`, followed by one delay flop. `rise` = synced level AND NOT delayed level.
- **FSM states:**
  - IDLE: when `en`=1, go to ARM.
  - ARM: on `rise`, go to MEAS and set `cnt`=1, `hi`=1.
  - MEAS: on `rise`, take a measurement, then set `cnt`=1, `hi`=1.
  - From ARM or MEAS, `en`=0 returns to IDLE.
- **Counting in MEAS:**
  - `cnt` increments by 1 every cycle; it saturates at 2^W-1.
  - `hi` increments on every cycle where the synced level is 1.
- **Measurement (`rise` in MEAS):**
  - `period` gets `cnt`, `high_cnt` gets `hi`, `meas_valid` pulses.
  - `period_err` = (|`cnt` - `exp_period`| > `tol`). The difference is computed unsigned at W+1 bits, then the absolute value is taken.
- **Lock:**
  - A measurement with no error increments a lock counter, which saturates at `LOCK_COUNT`.
  - `locked` asserts when the counter reaches `LOCK_COUNT`.
  - Any error measurement clears the counter and `locked`.
- **Timeout:**
  - In MEAS, if `cnt` reaches 2^W-1 with no `rise`: pulse `timeout`, clear the lock counter and `locked`, go to ARM.
  - ARM has no timeout.
- **First edge after arming:** it only starts counting. The first `meas_valid` comes on the second rising edge.
- **`en` deasserted:**
  - Clears the lock counter and `locked`, and the FSM goes to IDLE.
  - `period`, `high_cnt`, `period_err` and `duty_err` hold their values.
- **Simultaneous events:**
  - `en`=0 together with `rise`: `en` wins; no measurement.
  - `rise` on the saturation cycle: the measurement wins; no `timeout`.
- **Reset:** all outputs go to 0. That covers `period`, `high_cnt`, `meas_valid`, `period_err`, `duty_err`, `locked` and `timeout`. The FSM goes to IDLE, and the synchronizer, counters and lock counter go to 0. A mid-measurement reset discards the measurement in progress.

## Timing
- Latency from a `mon_in` rising transition to `rise` is `SYNC_STAGES`+1 `clk` edges. The latency is constant, so the measured period is exact for a `clk`-derived `mon_in`.
- `period`, `high_cnt`, `meas_valid` and `period_err` all update on the same edge; they are visible the cycle after `rise`.
- `locked` updates on that same edge.
- `meas_valid` and `timeout` are never high for more than one cycle.
- `exp_period` and `tol` are sampled on the measurement cycle only; changing them between measurements is legal.

## Configuration
- **`DUTY_CHECK_EN` defined:** the `hi` counter is built. `duty_err` = (|2*`hi` - `cnt`| > `tol`), updated with `meas_valid`. A duty error also clears the lock counter and `locked`.
- **`DUTY_CHECK_EN` not defined:**
  - The `hi` counter is removed.
  - `high_cnt` and `duty_err` are tied to 0.
  - Lock depends on the period check only.

## Test plan
- **Divide-by-4, `exp_period`=4, `tol`=0, `LOCK_COUNT`=4:** -> first `meas_valid` on the 2nd `mon_in` rise, with `period`=4 and `high_cnt`=2. `locked`=1 after the 4th `meas_valid`.
- **Divide-by-6 input with `exp_period`=4, then switch to divide-by-4:** -> `period_err`=1 and `locked`=0 while the input is divide-by-6. After the switch, `locked` rises only after 4 consecutive good measurements.
- **`exp_period`=5, `tol`=1:** a period of 6 -> `period_err`=0. A period of 7 -> `period_err`=1 and `locked` drops on the same edge.
- **W=8, `mon_in` held low after lock:** -> `timeout` pulses exactly once, 255 cycles after the last `rise`, with `locked`=0. The next two rises yield a fresh `meas_valid`.
- **`en`=0 coincident with `rise`, and `rst` pulsed mid-measurement:**
  - For `en`=0 -> no `meas_valid`; `period` holds.
  - For `rst` -> every output is 0 immediately (asynchronously); the first `meas_valid` after release needs two rises.
- **With `DUTY_CHECK_EN`, `mon_in` period 8 and high time 2, `tol`=1:** -> `duty_err`=1 and `locked` stays 0. Without the macro, `duty_err`=0 and `high_cnt`=0.
